// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl
//   Shares one single-port synchronous RAM between the core's instruction
//   port (read-only) and data port (read/write). Each access runs
//   IDLE -> ISSUE -> WAIT -> RESP, which takes RAM_LATENCY+3 cycles. The
//   requester holds req until it samples a one-cycle ready pulse.
//
//   Build option: define MEM_RR_ARB_EN for round-robin arbitration. When it
//   is not defined, the data port always wins a simultaneous request.
//
// Ports
//   clk                     single clock; the RAM uses the same edge
//   rst                     asynchronous reset, active low
//   i_req/i_addr            instruction read request and byte address
//   i_rdata/i_ready         instruction read data and completion pulse
//   d_req/d_wea/d_addr/d_wdata  data request; all-zero d_wea means a read
//   d_rdata/d_ready         data read result and completion pulse
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM side (word addressed)
//
// States
//   IDLE  | arbitrate and register the granted command
//   ISSUE | ram_en high for one cycle with the registered command
//   WAIT  | count down the RAM read latency, then capture read data
//   RESP  | ready pulse to the granted port
module unified_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_AW      = 18,
  parameter int RAM_LATENCY = 1,   // legal range 1..4
  localparam int BE_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic [BE_W-1:0]   d_wea,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_en,
  output logic [BE_W-1:0]   ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gnt_d_q, gnt_d_d;     // 1: data port owns the access
  logic               is_wr_q, is_wr_d;
  logic               ram_en_q, ram_en_d;
  logic [BE_W-1:0]    ram_we_q, ram_we_d;
  logic [RAM_AW-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
  logic               i_ready_q, i_ready_d;
  logic               d_ready_q, d_ready_d;
  logic               pick_d;

  // Only the word-address bits reach the RAM; the rest wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[ADDR_W-1:RAM_AW+2], i_addr[1:0],
                              d_addr[ADDR_W-1:RAM_AW+2], d_addr[1:0]};

`ifdef MEM_RR_ARB_EN
  logic last_d_q, last_d_d;                 // 1: data port granted last

  // On a tie, the port that did not win last time gets the RAM.
  assign pick_d = d_req && (!i_req || !last_d_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_d_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_d_q     <= gnt_d_d;
      is_wr_q     <= is_wr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Outputs are computed one cycle ahead so every port leaves a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d_d     = gnt_d_q;
    is_wr_d     = is_wr_q;
    ram_en_d    = 1'b0;
    ram_we_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
`ifdef MEM_RR_ARB_EN
    last_d_d    = last_d_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d  = pick_d;
          ram_en_d = 1'b1;
          state_d  = S_ISSUE;
`ifdef MEM_RR_ARB_EN
          last_d_d = pick_d;
`endif
          if (pick_d) begin
            ram_we_d    = d_wea;
            ram_addr_d  = d_addr[RAM_AW+1:2];
            ram_wdata_d = d_wdata;
            is_wr_d     = |d_wea;
          end else begin
            ram_addr_d  = i_addr[RAM_AW+1:2];
            ram_wdata_d = '0;
            is_wr_d     = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(RAM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!is_wr_q) begin
            if (gnt_d_q) d_rdata_d = ram_rdata;
            else         i_rdata_d = ram_rdata;
          end
          if (gnt_d_q) d_ready_d = 1'b1;
          else         i_ready_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;

endmodule
